core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have parameter IMEM_TIMEOUT, default 15, the maximum number of FETCH cycles spent waiting for imem_ready.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, begin execution; sampled in IDLE only.
REQ-006 SHALL have port stop, input, 1, request return to IDLE; sampled in WB only.
REQ-007 SHALL have port clear, input, 1, leave HALT/ERR and zero the counter.
REQ-008 SHALL have port step, input, 1, single-step advance; used only when SEQ_STEP_EN is defined.
REQ-009 SHALL have port imem_ready, input, 1, instruction memory data valid.
REQ-010 SHALL have port instr, input, 32, instruction word from instruction memory.
REQ-011 SHALL have port imem_req, output, 1, fetch request.
REQ-012 SHALL have port ir_load, output, 1, instruction-register load strobe.
REQ-013 SHALL have port rf_re, output, 1, register-file read strobe.
REQ-014 SHALL have port alu_go, output, 1, ALU execute strobe.
REQ-015 SHALL have port rf_we, output, 1, register-file write strobe.
REQ-016 SHALL have port pc_en, output, 1, PC advance strobe.
REQ-017 SHALL have port done, output, 1, halted flag.
REQ-018 SHALL have port err, output, 1, error flag.
REQ-019 SHALL have port state, output, 3, current state encoding.
REQ-020 SHALL have port instr_count, output, CNT_W, retired-instruction count.

Function
REQ-021 State encoding SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, ERR=6, PAUSE=7.
REQ-022 All strobes SHALL be Moore outputs of state plus registered flags, with no input-to-output combinational path except ir_load.
REQ-023 IDLE: all strobes 0; start=1 SHALL move to FETCH on the next edge, and start SHALL be ignored in every other state.
REQ-024 FETCH: imem_req=1 every cycle; ir_load=imem_ready (combinational); on imem_ready=1 the sequencer SHALL latch instr internally and go to DECODE.
REQ-025 FETCH wait counter SHALL reset on FETCH entry; after IMEM_TIMEOUT consecutive cycles with imem_ready=0 the sequencer SHALL go to ERR; ready arriving in the final allowed cycle SHALL win over the timeout.
REQ-026 DECODE: rf_re=1 for one cycle; latched opcode [31:26]=0 SHALL go to EXEC, 6'h3F SHALL go to HALT, and any other value SHALL go to ERR.
REQ-027 EXEC: alu_go=1 for one cycle, then WB.
REQ-028 WB: pc_en=1 and rf_we=1 for one cycle; rf_we SHALL be forced 0 when latched instr[15:11]==0.
REQ-029 WB: instr_count SHALL increment, saturating at all-ones.
REQ-030 WB exit SHALL be: stop=1 goes to IDLE; otherwise PAUSE if step mode applies; otherwise FETCH.
REQ-031 Minimum instruction latency with imem_ready tied high SHALL be 4 cycles (FETCH, DECODE, EXEC, WB).
REQ-032 HALT: done=1 held; ERR: err=1 held; clear=1 in either state SHALL go to IDLE, zero instr_count and drop the flag next edge.
REQ-033 clear SHALL be ignored in all states except HALT and ERR.
REQ-034 HALT and ERR SHALL NOT increment instr_count.

Reset
REQ-035 reset=0 SHALL immediately force state=IDLE, instr_count=0, latched instr=0, wait counter=0, done=0, err=0, and all strobes 0, asynchronously and including mid-fetch.
REQ-036 Release of reset SHALL be synchronous to clk, and the first state transition SHALL occur no earlier than the first rising edge after release.

Configuration
REQ-037 Macro SEQ_STEP_EN defined: after WB (stop=0) the sequencer SHALL enter PAUSE with all strobes 0, and step=1 SHALL move it to FETCH.
REQ-038 Macro SEQ_STEP_EN defined: stop=1 in PAUSE SHALL move it to IDLE, and stop SHALL take priority over step.
REQ-039 Macro SEQ_STEP_EN undefined: the step port SHALL remain present but be ignored, PAUSE SHALL be unreachable, and WB SHALL go directly to FETCH.

Verification
REQ-040 Bench SHALL cover: imem_ready=1 constant, start pulse, instr=32'h012A4020 x3 -> state sequence 1,2,3,4 repeating; instr_count=3 after 12 cycles; rf_we=1 in each WB.
REQ-041 Bench SHALL cover: instr=32'hFC000000 -> HALT after DECODE, done=1; clear pulse -> IDLE, instr_count=0.
REQ-042 Bench SHALL cover: imem_ready=0 for 15 cycles -> err=1, state=6; a separate run with ready on the 15th cycle -> DECODE, err=0.
REQ-043 Bench SHALL cover: instr=32'h00000020 (rd=0) -> rf_we=0 in WB, pc_en=1, count increments.
REQ-044 Bench SHALL cover: reset=0 asserted mid-FETCH -> all outputs 0 with no clock edge; SEQ_STEP_EN build: WB -> PAUSE held 5 cycles; step -> FETCH.

Source files
------------

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle instruction sequencer FSM (FETCH/DECODE/EXEC/WB).
// Optional single-step PAUSE state is enabled by defining SEQ_STEP_EN.
module core_sequencer #(
  parameter int CNT_W        = 16,
  parameter int IMEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             step,
  input  logic             imem_ready,
  input  logic [31:0]      instr,
  output logic             imem_req,
  output logic             ir_load,
  output logic             rf_re,
  output logic             alu_go,
  output logic             rf_we,
  output logic             pc_en,
  output logic             done,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6,
    S_PAUSE  = 3'd7
  } state_t;

  localparam int WAIT_W = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              imem_req_q, rf_re_q, alu_go_q, rf_we_q, pc_en_q, done_q, err_q;
  logic              pause_en, step_go;
  logic              unused_bits;

`ifdef SEQ_STEP_EN
  assign pause_en    = 1'b1;
  assign step_go     = step;
  assign unused_bits = ^{instr_q[25:16], instr_q[10:0]};
`else
  assign pause_en    = 1'b0;
  assign step_go     = 1'b0;
  assign unused_bits = ^{instr_q[25:16], instr_q[10:0], step};
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        // Ready in the last allowed cycle is checked first so it beats the timeout.
        if (imem_ready) begin
          instr_d = instr;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (instr_q[31:26] == 6'h00)      state_d = S_EXEC;
        else if (instr_q[31:26] == 6'h3F) state_d = S_HALT;
        else                              state_d = S_ERR;
      end
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (stop)          state_d = S_IDLE;
        else if (pause_en) state_d = S_PAUSE;
        else               state_d = S_FETCH;
      end
      S_HALT, S_ERR: begin
        if (clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_PAUSE: begin
        if (stop)         state_d = S_IDLE;
        else if (step_go) state_d = S_FETCH;
      end
      default:  state_d = S_IDLE;
    endcase
    if (state_d == S_FETCH && state_q != S_FETCH) wait_d = '0;
  end

  // Strobes are registered from the next state so they are clean Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      wait_q     <= '0;
      cnt_q      <= '0;
      imem_req_q <= 1'b0;
      rf_re_q    <= 1'b0;
      alu_go_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      imem_req_q <= (state_d == S_FETCH);
      rf_re_q    <= (state_d == S_DECODE);
      alu_go_q   <= (state_d == S_EXEC);
      rf_we_q    <= (state_d == S_WB) && (instr_d[15:11] != 5'd0);
      pc_en_q    <= (state_d == S_WB);
      done_q     <= (state_d == S_HALT);
      err_q      <= (state_d == S_ERR);
    end
  end

  assign imem_req    = imem_req_q;
  assign ir_load     = (state_q == S_FETCH) && imem_ready;
  assign rf_re       = rf_re_q;
  assign alu_go      = alu_go_q;
  assign rf_we       = rf_we_q;
  assign pc_en       = pc_en_q;
  assign done        = done_q;
  assign err         = err_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - scoreboard bench for core_sequencer.
`timescale 1ns/1ps
module tb_core_sequencer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0, stop = 1'b0, clear = 1'b0, step = 1'b0;
  logic             imem_ready = 1'b0;
  logic [31:0]      instr = 32'h0;
  logic             imem_req, ir_load, rf_re, alu_go, rf_we, pc_en, done, err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  core_sequencer #(.CNT_W(CNT_W), .IMEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .step(step),
    .imem_ready(imem_ready), .instr(instr), .imem_req(imem_req), .ir_load(ir_load),
    .rf_re(rf_re), .alu_go(alu_go), .rf_we(rf_we), .pc_en(pc_en), .done(done), .err(err),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [10:0]      v;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] ecnt = '0;

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_HALT = 32'hFC000000;
  localparam logic [31:0] I_RD0  = 32'h00000020;
  localparam logic [31:0] I_BAD  = 32'h04000000;

  // {state, imem_req, ir_load, rf_re, alu_go, rf_we, pc_en, done, err}
  function automatic logic [10:0] model(input logic [2:0] s, input logic rdz, input logic rdy);
    model = {s, s == 3'd1, (s == 3'd1) && rdy, s == 3'd2, s == 3'd3,
             (s == 3'd4) && !rdz, s == 3'd4, s == 3'd5, s == 3'd6};
  endfunction

  task automatic push(input string nm, input logic [2:0] es, input logic rdz);
    exp_t e;
    e.name = nm;
    e.v    = model(es, rdz, imem_ready);
    e.cnt  = ecnt;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1: apply inputs, record expected outputs for this cycle, advance.
  task automatic cyc(input string nm, input logic st, input logic sp, input logic cl,
                     input logic stp, input logic rdy, input logic [31:0] ins, input logic [2:0] es);
    start = st; stop = sp; clear = cl; step = stp; imem_ready = rdy; instr = ins;
    push(nm, es, ins[15:11] == 5'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic instr_run(input logic [31:0] ins, input logic stop_wb);
    cyc("fetch",  0, 0, 0, 0, 1, ins, 3'd1);
    cyc("decode", 1, 0, 0, 0, 1, ins, 3'd2);
    cyc("exec",   0, 0, 1, 0, 1, ins, 3'd3);
    cyc("wb",     0, stop_wb, 0, 0, 1, ins, 3'd4);
    ecnt = ecnt + 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e   = exp_q.pop_front();
      act = {state, imem_req, ir_load, rf_re, alu_go, rf_we, pc_en, done, err};
      checks++;
      if (act !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL %s: got state=%0d flags=%b cnt=%0d, expected state=%0d flags=%b cnt=%0d",
                 e.name, act[10:8], act[7:0], instr_count, e.v[10:8], e.v[7:0], e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    cyc("reset_held", 1, 0, 0, 0, 1, I_ADD, 3'd0);
    reset = 1'b1;

    // Three back-to-back instructions, stop on the last WB.
    cyc("idle_start", 1, 0, 0, 0, 1, I_ADD, 3'd0);
    for (int k = 0; k < 3; k++) instr_run(I_ADD, k == 2);
    cyc("idle_clear_ignored", 0, 0, 1, 0, 0, 32'h0, 3'd0);

    // HALT opcode, then clear.
    cyc("start_h", 1, 0, 0, 0, 1, I_HALT, 3'd0);
    cyc("fetch_h", 0, 0, 0, 0, 1, I_HALT, 3'd1);
    cyc("decode_h", 0, 0, 0, 0, 1, I_HALT, 3'd2);
    cyc("halt", 1, 0, 0, 0, 1, I_HALT, 3'd5);
    cyc("halt_hold", 0, 1, 0, 0, 1, I_HALT, 3'd5);
    cyc("halt_clear", 0, 0, 1, 0, 0, 32'h0, 3'd5);
    ecnt = '0;
    cyc("idle_after_halt", 0, 0, 0, 0, 0, 32'h0, 3'd0);

    // Fetch timeout: 15 cycles without ready.
    cyc("start_t", 1, 0, 0, 0, 0, 32'h0, 3'd0);
    for (int i = 0; i < 15; i++) cyc("fetch_wait", 0, 0, 0, 0, 0, 32'h0, 3'd1);
    cyc("err_timeout", 0, 0, 0, 0, 0, 32'h0, 3'd6);
    cyc("err_clear", 0, 0, 1, 0, 0, 32'h0, 3'd6);
    ecnt = '0;
    cyc("idle_after_err", 0, 0, 0, 0, 0, 32'h0, 3'd0);

    // Illegal opcode.
    cyc("start_b", 1, 0, 0, 0, 1, I_BAD, 3'd0);
    cyc("fetch_b", 0, 0, 0, 0, 1, I_BAD, 3'd1);
    cyc("decode_b", 0, 0, 0, 0, 1, I_BAD, 3'd2);
    cyc("err_opcode", 0, 0, 0, 0, 1, I_BAD, 3'd6);
    cyc("err_clear_b", 0, 0, 1, 0, 1, I_BAD, 3'd6);
    ecnt = '0;
    cyc("idle_after_b", 0, 0, 0, 0, 0, 32'h0, 3'd0);

    // Ready on the 15th fetch cycle wins; rd=0 suppresses rf_we.
    cyc("start_r", 1, 0, 0, 0, 0, 32'h0, 3'd0);
    for (int i = 0; i < 14; i++) cyc("fetch_wait_r", 0, 0, 0, 0, 0, 32'h0, 3'd1);
    instr_run(I_RD0, 1'b1);
    cyc("idle_after_rd0", 0, 0, 0, 1, 0, 32'h0, 3'd0);

    // WB exit without stop.
    cyc("start_s", 1, 0, 0, 0, 1, I_ADD, 3'd0);
    instr_run(I_ADD, 1'b0);
`ifdef SEQ_STEP_EN
    for (int i = 0; i < 5; i++) cyc("pause_hold", 1, 0, 1, 0, 1, I_ADD, 3'd7);
    cyc("pause_step", 0, 0, 0, 1, 1, I_ADD, 3'd7);
    instr_run(I_ADD, 1'b0);
    cyc("pause_stop_prio", 0, 1, 0, 1, 1, I_ADD, 3'd7);
`else
    instr_run(I_ADD, 1'b1);
`endif
    cyc("idle_after_step", 0, 0, 0, 0, 0, 32'h0, 3'd0);

    // Asynchronous reset in the middle of a fetch.
    cyc("start_x", 1, 0, 0, 0, 0, 32'h0, 3'd0);
    cyc("fetch_x1", 0, 0, 0, 0, 0, 32'h0, 3'd1);
    cyc("fetch_x2", 0, 0, 0, 0, 0, 32'h0, 3'd1);
    #2;
    imem_ready = 1'b1;
    reset = 1'b0;
    ecnt = '0;
    push("reset_async", 3'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("idle_post_reset", 1, 0, 0, 0, 1, I_ADD, 3'd0);
    instr_run(I_ADD, 1'b1);
    cyc("idle_final", 0, 0, 0, 0, 0, 32'h0, 3'd0);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
